// File: rtl/instr_fetch_pkg.sv
// Shared CPU fetch definitions: FSM state encoding, reset PC, NOP word and
// the word-alignment helper used on redirect targets.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FULL = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: a redirect loads the word-aligned target and wins over
// the +4 advance; one-cycle update, no backpressure of its own.
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_target,
    input  logic [31:0] target,
    input  logic        incr,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_target) begin
            pc_d = word_align(target);
        end else if (incr) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> FULL, 3-cycle minimum issue interval.
// Holds the request until granted and the instruction until consumed; redirects kill in-flight data.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        i_InstrFetch_clk,
    input  logic        i_InstrFetch_rst,
    output logic        o_InstrFetch_imemReq,
    output logic [31:0] o_InstrFetch_imemAddr,
    input  logic        i_InstrFetch_imemGnt,
    input  logic        i_InstrFetch_imemRvalid,
    input  logic [31:0] i_InstrFetch_imemRdata,
    output logic        o_InstrFetch_valid,
    input  logic        i_InstrFetch_ready,
    output logic [31:0] o_InstrFetch_instr,
    output logic [5:0]  o_InstrFetch_opcode,
    output logic [5:0]  o_InstrFetch_funct,
    output logic [31:0] o_InstrFetch_pc,
    output logic [31:0] o_InstrFetch_pcPlus4,
    input  logic        i_InstrFetch_redirect,
    input  logic [31:0] i_InstrFetch_target
);

    if_state_e   state_q, state_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] pc;
    logic        pc_incr;

    // Every redirect retargets the PC regardless of state.
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (i_InstrFetch_clk),
        .rst         (i_InstrFetch_rst),
        .load_target (i_InstrFetch_redirect),
        .target      (i_InstrFetch_target),
        .incr        (pc_incr),
        .pc          (pc)
    );

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        imem_req_d = imem_req_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_incr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                imem_req_d = 1'b1;
            end
            ST_REQ: begin
                if (i_InstrFetch_imemGnt) begin
                    state_d    = ST_WAIT;
                    imem_req_d = 1'b0;
                    kill_d     = i_InstrFetch_redirect;
                end
            end
            ST_WAIT: begin
                if (i_InstrFetch_imemRvalid) begin
                    if (kill_q || i_InstrFetch_redirect) begin
                        kill_d     = 1'b0;
                        state_d    = ST_REQ;
                        imem_req_d = 1'b1;
                    end else begin
                        instr_d    = i_InstrFetch_imemRdata;
                        instr_pc_d = pc;
                        pc_incr    = 1'b1;
                        valid_d    = 1'b1;
                        state_d    = ST_FULL;
                    end
                end else if (i_InstrFetch_redirect) begin
                    kill_d = 1'b1;
                end
            end
            ST_FULL: begin
                // A redirect coinciding with ready still counts as the consume.
                if (i_InstrFetch_ready || i_InstrFetch_redirect) begin
                    valid_d    = 1'b0;
                    state_d    = ST_REQ;
                    imem_req_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                imem_req_d = 1'b0;
                valid_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_InstrFetch_clk or posedge i_InstrFetch_rst) begin
        if (i_InstrFetch_rst) begin
            state_q    <= ST_IDLE;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            imem_req_q <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            imem_req_q <= imem_req_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign o_InstrFetch_imemReq  = imem_req_q;
    assign o_InstrFetch_imemAddr = pc;
    assign o_InstrFetch_valid    = valid_q;
    assign o_InstrFetch_instr    = instr_q;
    assign o_InstrFetch_opcode   = instr_q[31:26];
    assign o_InstrFetch_funct    = instr_q[5:0];
    assign o_InstrFetch_pc       = instr_pc_q;
    assign o_InstrFetch_pcPlus4  = instr_pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: the bench plays instruction memory and
// decode stage, and tracks fetches as transactions in a scoreboard.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] target;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RST_PC)
    ) dut (
        .i_InstrFetch_clk        (clk),
        .i_InstrFetch_rst        (rst),
        .o_InstrFetch_imemReq    (imem_req),
        .o_InstrFetch_imemAddr   (imem_addr),
        .i_InstrFetch_imemGnt    (imem_gnt),
        .i_InstrFetch_imemRvalid (imem_rvalid),
        .i_InstrFetch_imemRdata  (imem_rdata),
        .o_InstrFetch_valid      (if_valid),
        .i_InstrFetch_ready      (if_ready),
        .o_InstrFetch_instr      (instr),
        .o_InstrFetch_opcode     (opcode),
        .o_InstrFetch_funct      (funct),
        .o_InstrFetch_pc         (pc),
        .o_InstrFetch_pcPlus4    (pc_plus4),
        .i_InstrFetch_redirect   (redirect),
        .i_InstrFetch_target     (target)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Scoreboard: next address to fetch, the one request in flight, the held instruction.
    logic [31:0] exp_pc;
    bit          inflight, inf_killed, held;
    logic [31:0] inf_addr, held_addr, held_data;
    int          rv_cnt;
    int          consumed;

    int gnt_pct, rdy_pct, redir_pct, spur_pct, rv_min, rv_max;
    bit          force_redir, force_data_en;
    logic [31:0] force_tgt, force_data;

    bit          s_req, s_valid;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic sample();
        @(negedge clk);
        s_req   = imem_req;
        s_valid = if_valid;
        s_addr  = imem_addr;
        chk("valid", 32'(if_valid), 32'(held));
        chk("imem_req", 32'(imem_req), 32'(!(inflight || held)));
        if (held) begin
            chk("instr", instr, held_data);
            chk("pc", pc, held_addr);
            chk("pc_plus4", pc_plus4, held_addr + 32'd4);
            chk("opcode", 32'(opcode), 32'(held_data[31:26]));
            chk("funct", 32'(funct), 32'(held_data[5:0]));
        end
        if (imem_req) chk("imem_addr", imem_addr, exp_pc);
    endtask

    task automatic drive();
        bit          g, rv, rd, rdr;
        logic [31:0] tg, dat;
        bit          deliver;
        g   = ($urandom_range(99) < gnt_pct);
        rd  = ($urandom_range(99) < rdy_pct);
        rdr = ($urandom_range(99) < redir_pct);
        tg  = $urandom;
        dat = $urandom;
        rv  = 1'b0;
        deliver = inflight && (rv_cnt == 0);
        if (deliver) begin
            rv  = 1'b1;
            dat = force_data_en ? force_data : mem_word(inf_addr);
            force_data_en = 1'b0;
        end else if (!inflight && ($urandom_range(99) < spur_pct)) begin
            rv = 1'b1;
        end
        if (force_redir) begin
            rdr = 1'b1;
            tg  = force_tgt;
            force_redir = 1'b0;
        end
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = dat;
        if_ready    = rd;
        redirect    = rdr;
        target      = tg;
        // Effects of this cycle, in the order they resolve at the clock edge.
        if (s_valid && rd) consumed++;
        if (held && rd) held = 1'b0;
        if (deliver) begin
            if (!inf_killed) begin
                held      = 1'b1;
                held_addr = inf_addr;
                held_data = dat;
                exp_pc    = inf_addr + 32'd4;
            end
            inflight = 1'b0;
        end else if (inflight) begin
            rv_cnt--;
        end
        if (s_req && g) begin
            inflight   = 1'b1;
            inf_addr   = exp_pc;
            inf_killed = 1'b0;
            rv_cnt     = $urandom_range(rv_max, rv_min);
        end
        if (rdr) begin
            exp_pc = tg & 32'hFFFF_FFFC;
            if (inflight) inf_killed = 1'b1;
            held = 1'b0;
        end
    endtask

    task automatic wait_for(input bit want_valid, input int budget, input string tag);
        int n;
        n = 0;
        sample();
        while (!(want_valid ? s_valid : s_req) && n < budget) begin
            drive();
            sample();
            n++;
        end
        chk(tag, 32'(want_valid ? s_valid : s_req), 32'd1);
    endtask

    task automatic do_reset(input bit stale, input bit idle_redir, input logic [31:0] tg);
        @(negedge clk);
        #2;
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0; redirect = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0000);
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        chk("rst_addr", imem_addr, RST_PC);
        inflight = 1'b0; held = 1'b0; exp_pc = RST_PC;
        force_redir = 1'b0; force_data_en = 1'b0;
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = stale;
        imem_rdata  = 32'hBAD0_BAD0;
        redirect    = idle_redir;
        target      = tg;
        if (idle_redir) exp_pc = tg & 32'hFFFF_FFFC;
    endtask

    logic [31:0] aq[$];
    int          acq[$], vcq[$];
    logic [31:0] i0, p0, a0;
    int          c0;

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        if_ready = 1'b0; redirect = 1'b0; target = '0;
        consumed = 0; rv_cnt = 0;
        inflight = 1'b0; inf_killed = 1'b0; held = 1'b0; exp_pc = RST_PC;
        inf_addr = '0; held_addr = '0; held_data = '0;
        force_redir = 1'b0; force_data_en = 1'b0; force_tgt = '0; force_data = '0;
        gnt_pct = 100; rdy_pct = 100; redir_pct = 0; spur_pct = 0; rv_min = 0; rv_max = 0;
        do_reset(1'b0, 1'b0, 32'h0);

        // Back-to-back stream: zero-latency grant, one-cycle data, always ready.
        for (int c = 0; c < 12; c++) begin
            sample();
            if (s_req) begin aq.push_back(s_addr); acq.push_back(c); end
            if (s_valid) vcq.push_back(c);
            drive();
        end
        chk("seq_addr0", aq[0], 32'h0000_3000);
        chk("seq_addr1", aq[1], 32'h0000_3004);
        chk("seq_addr2", aq[2], 32'h0000_3008);
        chk("seq_issue_gap", 32'(acq[2] - acq[1]), 32'd3);
        chk("seq_valid_gap", 32'(vcq[1] - vcq[0]), 32'd3);

        // Decode stalls for five cycles while an instruction is held.
        rdy_pct = 0;
        wait_for(1'b1, 10, "to_full");
        i0 = instr; p0 = pc;
        drive();
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("stall_instr", instr, i0);
            chk("stall_req", 32'(imem_req), 32'd0);
            if (k == 4) rdy_pct = 100;
            drive();
        end
        sample();
        chk("stall_next_req", 32'(imem_req), 32'd1);
        chk("stall_next_addr", imem_addr, p0 + 32'd4);
        drive();

        // Grant withheld: request and address must not move.
        gnt_pct = 0;
        wait_for(1'b0, 10, "to_req");
        a0 = s_addr;
        drive();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("hold_req", 32'(imem_req), 32'd1);
            chk("hold_addr", imem_addr, a0);
            drive();
        end

        // Redirect while waiting for data; the returning word must be dropped.
        gnt_pct = 100; rv_min = 1; rv_max = 1;
        wait_for(1'b0, 10, "to_req2");
        drive();
        sample();
        force_redir = 1'b1; force_tgt = 32'h0040_0010;
        force_data_en = 1'b1; force_data = 32'hDEAD_BEEF;
        drive();
        sample();
        drive();
        sample();
        chk("wait_redir_valid", 32'(if_valid), 32'd0);
        chk("wait_redir_req", 32'(imem_req), 32'd1);
        chk("wait_redir_addr", imem_addr, 32'h0040_0010);
        drive();

        // Redirect to an unaligned target in the same cycle as the consume.
        rv_min = 0; rv_max = 0; rdy_pct = 0;
        wait_for(1'b1, 10, "to_full2");
        c0 = consumed;
        rdy_pct = 100; force_redir = 1'b1; force_tgt = 32'h0000_3103;
        drive();
        sample();
        chk("full_redir_consume", 32'(consumed - c0), 32'd1);
        chk("full_redir_req", 32'(imem_req), 32'd1);
        chk("full_redir_addr", imem_addr, 32'h0000_3100);
        drive();

        // Fetch from the top word of the address space.
        rdy_pct = 0;
        sample();
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
        drive();
        wait_for(1'b1, 12, "to_full3");
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        rdy_pct = 100;
        drive();
        wait_for(1'b0, 10, "to_req3");
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        drive();

        // Reset with a request outstanding, then a stale rvalid after release.
        rv_min = 2; rv_max = 2;
        wait_for(1'b0, 10, "to_req4");
        drive();
        sample();
        drive();
        do_reset(1'b1, 1'b0, 32'h0);
        sample();
        chk("post_rst_addr", imem_addr, RST_PC);
        chk("post_rst_valid", 32'(if_valid), 32'd0);
        drive();
        do_reset(1'b0, 1'b1, 32'h0000_5006);
        sample();
        chk("idle_redir_addr", imem_addr, 32'h0000_5004);
        drive();

        // Randomized traffic in blocks with varying pressure, occasional resets.
        rv_min = 0;
        for (int blk = 0; blk < 15; blk++) begin
            gnt_pct   = $urandom_range(100, 30);
            rdy_pct   = $urandom_range(100, 20);
            redir_pct = $urandom_range(12, 0);
            spur_pct  = $urandom_range(20, 0);
            rv_max    = $urandom_range(3, 0);
            for (int k = 0; k < 200; k++) begin
                sample();
                drive();
            end
            if (blk % 5 == 4) do_reset(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
        end
        chk("progress", 32'(consumed > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
